// File: rtl/pool2x2_window_pkg.sv
// Shared definitions for the 2x2 stride-2 pooling window stage:
// row-phase state encoding, pooling-mode constants and a width helper.
package pool2x2_window_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EVEN_ROW = 2'd1,
    ODD_ROW  = 2'd2
  } state_t;

  localparam int POOL_MAX = 1;
  localparam int POOL_AVG = 0;

  // Bits needed to count 0..v-1; never less than 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pool2x2_window_pair_combine.sv
// Combinational pairwise combine: widened signed sum (average mode)
// or signed maximum (max mode), on two sign-extended operands.
module pool_pair_combine
  import pool2x2_window_pkg::*;
#(
  parameter int N     = 8,
  parameter int ptype = POOL_MAX
) (
  input  logic signed [N:0]   a,
  input  logic signed [N:0]   b,
  output logic signed [N+1:0] y
);

  always_comb begin
    y = '0;
    if (ptype == POOL_AVG) begin
      y = {a[N], a} + {b[N], b};
    end else begin
      y = (a > b) ? {a[N], a} : {b[N], b};
    end
  end

endmodule

// File: rtl/pool2x2_window.sv
// Streaming 2x2 stride-2 pooling window: pairs pixels horizontally, keeps
// one half-row of partial results, and emits one pooled pixel per window.
//
// state    | meaning
// IDLE     | waiting for start, input closed
// EVEN_ROW | first row of a window pair; horizontal results go to line buffer
// ODD_ROW  | second row; line buffer entry combined with h into a result
module pool2x2_window
  import pool2x2_window_pkg::*;
#(
  parameter int N     = 8,
  parameter int Q     = 4,
  parameter int ptype = 1,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW   = (clog2(IMG_W) < 2) ? 2 : clog2(IMG_W);
  localparam int RW   = clog2(IMG_H);
  localparam int LB_D = IMG_W / 2;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [N-1:0]   pair_q, pair_d;
  logic           last_in_q, last_in_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           busy_q, busy_d;
  logic           frame_done_q, frame_done_d;

  logic [N:0]     lb_q [LB_D];

  logic              in_hs, col_last, row_last, load, drain, final_hs;
  logic [CW-2:0]     lb_idx;
  logic [N:0]        lb_rd, h_st;
  logic signed [N:0] h_a, h_b, v_a, v_b;
  logic signed [N+1:0] h_y, v_y, v_sh;
  logic [N-1:0]      res;
  logic              unused_bits;

  assign in_ready = ce && busy_q && !last_in_q && (!out_valid_q || out_ready);
  assign in_hs    = in_valid && in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign lb_idx   = col_q[CW-1:1];
  assign lb_rd    = lb_q[lb_idx];

  assign h_a = {pair_q[N-1], pair_q};
  assign h_b = {in_data[N-1], in_data};
  // Max results fit in N bits, so the stored top bit is kept at zero.
  assign h_st = (ptype == POOL_MAX) ? {1'b0, h_y[N-1:0]} : h_y[N:0];
  assign v_a  = (ptype == POOL_MAX) ? {lb_rd[N-1], lb_rd[N-1:0]} : lb_rd;
  assign v_b  = h_y[N:0];
  assign v_sh = v_y >>> 2;
  assign res  = (ptype == POOL_MAX) ? v_y[N-1:0] : v_sh[N-1:0];
  assign unused_bits = ^{h_y[N+1], v_sh[N+1:N]};

  pool_pair_combine #(.N(N), .ptype(ptype)) u_h_combine (.a(h_a), .b(h_b), .y(h_y));
  pool_pair_combine #(.N(N), .ptype(ptype)) u_v_combine (.a(v_a), .b(v_b), .y(v_y));

  assign load     = in_hs && (state_q == ODD_ROW) && col_q[0];
  assign drain    = ce && out_valid_q && out_ready;
  assign final_hs = drain && last_in_q;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    last_in_d    = last_in_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    if (ce) begin
      frame_done_d = 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_d   = EVEN_ROW;
          busy_d    = 1'b1;
          col_d     = '0;
          row_d     = '0;
          last_in_d = 1'b0;
        end
        EVEN_ROW: if (in_hs && col_last) state_d = ODD_ROW;
        ODD_ROW: begin
          if (in_hs && col_last && !row_last) state_d = EVEN_ROW;
          if (in_hs && col_last && row_last) last_in_d = 1'b1;
          if (final_hs) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
            last_in_d    = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (in_hs) begin
        if (!col_q[0]) pair_d = in_data;
        col_d = col_last ? '0 : col_q + 1'b1;
        if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
      end
      if (drain) out_valid_d = 1'b0;
      if (load) begin
        out_valid_d = 1'b1;
        out_data_d  = res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      last_in_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      last_in_q    <= last_in_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_hs && (state_q == EVEN_ROW) && col_q[0]) lb_q[lb_idx] <= h_st;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2x2_window.sv
// Directed bench for pool2x2_window on a 4x4 frame; a max and an average
// instance share the input stream so both modes are checked per frame.
module tb_pool2x2_window;

  logic       clk = 1'b0;
  logic       rst_n, ce, start, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready_m, out_valid_m, busy_m, frame_done_m;
  logic       in_ready_a, out_valid_a, busy_a, frame_done_a;
  logic [7:0] out_data_m, out_data_a;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  int fd_cyc = 0;
  bit fd_seen = 0;
  logic fd_busy = 1'b0;
  logic [7:0] q_m[$];
  logic [7:0] q_a[$];

  pool2x2_window #(.N(8), .Q(4), .ptype(1), .IMG_W(4), .IMG_H(4)) u_max (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_m), .in_data(in_data), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_data(out_data_m), .busy(busy_m),
    .frame_done(frame_done_m));

  pool2x2_window #(.N(8), .Q(4), .ptype(0), .IMG_W(4), .IMG_H(4)) u_avg (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_data(in_data), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a),
    .frame_done(frame_done_a));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ce && out_ready && out_valid_m) begin
      q_m.push_back(out_data_m);
      last_hs_cyc = cyc;
    end
    if (ce && out_ready && out_valid_a) q_a.push_back(out_data_a);
    if (frame_done_m) begin
      fd_seen = 1;
      fd_cyc  = cyc;
      fd_busy = busy_m;
    end
  end

  task automatic clear_mon();
    q_m.delete();
    q_a.delete();
    fd_seen = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] v);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (t < 200) begin
      @(negedge clk);
      if (in_ready_m) break;
      t++;
    end
    tests_run++;
    if (t >= 200) begin
      tests_failed++;
      $display("FAIL send_timeout pixel=%0h in_ready=%0b required=1", v, in_ready_m);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!fd_seen && t < 100) begin
      @(negedge clk);
      t++;
    end
    tests_run++;
    if (!fd_seen) begin
      tests_failed++;
      $display("FAIL frame_done_timeout seen=0 required=1");
    end else begin
      tests_run++;
      if (fd_cyc !== last_hs_cyc + 1) begin
        tests_failed++;
        $display("FAIL frame_done_timing cycle=%0d required=%0d", fd_cyc, last_hs_cyc + 1);
      end
      tests_run++;
      if (fd_busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL busy_at_done busy=%0b required=0", fd_busy);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    tests_run++;
    if ({in_ready_m, out_valid_m, out_data_m, busy_m, frame_done_m} !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%0h required=0", {in_ready_m, out_valid_m, out_data_m, busy_m, frame_done_m});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if (in_ready_m !== 1'b0 || out_valid_m !== 1'b0 || busy_m !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_ignores_input in_ready=%0b out_valid=%0b busy=%0b required=0",
                 in_ready_m, out_valid_m, busy_m);
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_frame_basic();
    logic [7:0] em[4], ea[4];
    em = '{8'd6, 8'd8, 8'd14, 8'd16};
    ea = '{8'd3, 8'd5, 8'd11, 8'd13};
    clear_mon();
    pulse_start();
    tests_run++;
    if (busy_m !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_start busy=%0b required=1", busy_m);
    end
    for (int i = 0; i < 16; i++) send_pixel(8'(i + 1));
    wait_done();
    tests_run++;
    if (q_m.size() != 4 || q_a.size() != 4) begin
      tests_failed++;
      $display("FAIL basic_count max=%0d avg=%0d required=4", q_m.size(), q_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (q_m[i] !== em[i] || q_a[i] !== ea[i]) begin
          tests_failed++;
          $display("FAIL basic_out[%0d] max=%0d avg=%0d required max=%0d avg=%0d",
                   i, q_m[i], q_a[i], em[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_negative();
    logic [7:0] px[16], em[4], ea[4];
    px = '{8'hF0, 8'hF8, 8'h7F, 8'h7F,
           8'h80, 8'hFF, 8'h7F, 8'h7F,
           8'h80, 8'h80, 8'hFF, 8'h00,
           8'h80, 8'h80, 8'h00, 8'h00};
    em = '{8'hFF, 8'h7F, 8'h80, 8'h00};
    ea = '{8'hD9, 8'h7F, 8'h80, 8'hFF};
    clear_mon();
    pulse_start();
    for (int i = 0; i < 16; i++) send_pixel(px[i]);
    wait_done();
    tests_run++;
    if (q_m.size() != 4 || q_a.size() != 4) begin
      tests_failed++;
      $display("FAIL neg_count max=%0d avg=%0d required=4", q_m.size(), q_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (q_m[i] !== em[i] || q_a[i] !== ea[i]) begin
          tests_failed++;
          $display("FAIL neg_out[%0d] max=%0h avg=%0h required max=%0h avg=%0h",
                   i, q_m[i], q_a[i], em[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] em[4], ea[4];
    em = '{8'd6, 8'd8, 8'd14, 8'd16};
    ea = '{8'd3, 8'd5, 8'd11, 8'd13};
    clear_mon();
    pulse_start();
    fork
      begin
        for (int i = 0; i < 16; i++) send_pixel(8'(i + 1));
      end
      begin
        int t;
        t = 0;
        while (!out_valid_m && t < 100) begin
          @(posedge clk); #1;
          t++;
        end
        out_ready = 1'b0;
        repeat (6) begin
          @(negedge clk);
          tests_run++;
          if (out_valid_m !== 1'b1 || out_data_m !== 8'd6 || out_data_a !== 8'd3 || in_ready_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_hold valid=%0b max=%0d avg=%0d in_ready=%0b required 1/6/3/0",
                     out_valid_m, out_data_m, out_data_a, in_ready_m);
          end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done();
    tests_run++;
    if (q_m.size() != 4 || q_a.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count max=%0d avg=%0d required=4", q_m.size(), q_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (q_m[i] !== em[i] || q_a[i] !== ea[i]) begin
          tests_failed++;
          $display("FAIL bp_out[%0d] max=%0d avg=%0d required max=%0d avg=%0d",
                   i, q_m[i], q_a[i], em[i], ea[i]);
        end
      end
    end
  endtask

  task automatic test_clock_enable();
    logic [7:0] em[4];
    em = '{8'd6, 8'd8, 8'd14, 8'd16};
    clear_mon();
    pulse_start();
    for (int i = 0; i < 6; i++) send_pixel(8'(i + 1));
    ce = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd7;
    repeat (5) begin
      @(negedge clk);
      tests_run++;
      if (in_ready_m !== 1'b0 || out_valid_m !== 1'b1 || out_data_m !== 8'd6 ||
          out_data_a !== 8'd3 || busy_m !== 1'b1) begin
        tests_failed++;
        $display("FAIL ce_freeze in_ready=%0b valid=%0b max=%0d avg=%0d busy=%0b required 0/1/6/3/1",
                 in_ready_m, out_valid_m, out_data_m, out_data_a, busy_m);
      end
    end
    @(posedge clk); #1 ce = 1'b1; in_valid = 1'b0;
    for (int i = 6; i < 16; i++) send_pixel(8'(i + 1));
    wait_done();
    tests_run++;
    if (q_m.size() != 4) begin
      tests_failed++;
      $display("FAIL ce_count got=%0d required=4", q_m.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (q_m[i] !== em[i]) begin
          tests_failed++;
          $display("FAIL ce_out[%0d] got=%0d required=%0d", i, q_m[i], em[i]);
        end
      end
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] em[4], ea[4];
    em = '{8'd6, 8'd8, 8'd14, 8'd16};
    ea = '{8'd3, 8'd5, 8'd11, 8'd13};
    clear_mon();
    out_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 6; i++) send_pixel(8'(i + 1));
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready_m, out_valid_m, out_data_m, busy_m, frame_done_m} !== 12'h000) begin
      tests_failed++;
      $display("FAIL async_reset got=%0h required=0", {in_ready_m, out_valid_m, out_data_m, busy_m, frame_done_m});
    end
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    clear_mon();
    pulse_start();
    for (int i = 0; i < 3; i++) send_pixel(8'(i + 1));
    pulse_start();
    for (int i = 3; i < 16; i++) send_pixel(8'(i + 1));
    wait_done();
    tests_run++;
    if (q_m.size() != 4 || q_a.size() != 4) begin
      tests_failed++;
      $display("FAIL rst_count max=%0d avg=%0d required=4", q_m.size(), q_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (q_m[i] !== em[i] || q_a[i] !== ea[i]) begin
          tests_failed++;
          $display("FAIL rst_out[%0d] max=%0d avg=%0d required max=%0d avg=%0d",
                   i, q_m[i], q_a[i], em[i], ea[i]);
        end
      end
    end
    tests_run++;
    if (busy_m !== 1'b0 || in_ready_m !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_frame busy=%0b in_ready=%0b required=0", busy_m, in_ready_m);
    end
  endtask

  initial begin
    test_reset();
    test_frame_basic();
    test_negative();
    test_backpressure();
    test_clock_enable();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
